// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: register-index width,
// forwarding-source encodings and the shadow scoreboard entry layout.
package hazard_unit_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic             rfWe;
        logic             isLoad;
        logic [REG_W-1:0] wR;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // A stage can only supply a value if it really writes a non-zero register.
    function automatic logic isSource(input sb_entry_t e);
        return e.valid && e.rfWe && (e.wR != '0);
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c, input logic en);
        if (en && (c != {CNT_W{1'b1}})) begin
            return c + 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Per-operand hazard comparison: picks the youngest in-flight producer of one
// source register and flags a load-use hit against the EX stage.
module hazard_fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic             i_re,
    input  logic [REG_W-1:0] i_rR,
    input  logic             i_exSrc,
    input  logic             i_exLoad,
    input  logic [REG_W-1:0] i_exWR,
    input  logic             i_memSrc,
    input  logic [REG_W-1:0] i_memWR,
    input  logic             i_wbSrc,
    input  logic [REG_W-1:0] i_wbWR,
    output logic [1:0]       o_sel,
    output logic             o_loadHit
);

    logic     w_readValid;
    logic     w_exHit;
    logic     w_memHit;
    logic     w_wbHit;
    fwd_sel_e w_sel;

    assign w_readValid = i_re && (i_rR != '0);
    assign w_exHit     = w_readValid && i_exSrc  && (i_exWR  == i_rR);
    assign w_memHit    = w_readValid && i_memSrc && (i_memWR == i_rR);
    assign w_wbHit     = w_readValid && i_wbSrc  && (i_wbWR  == i_rR);

    assign o_loadHit   = w_exHit && i_exLoad;

    // A load in EX is the youngest writer, so older stages would be stale;
    // the regfile code is returned and the stall covers the dependency.
    always_comb begin
        w_sel = FWD_RF;
        if (w_exHit) begin
            w_sel = i_exLoad ? FWD_RF : FWD_EX;
        end else if (w_memHit) begin
            w_sel = FWD_MEM;
        end else if (w_wbHit) begin
            w_sel = FWD_WB;
        end
    end

    assign o_sel = w_sel;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: shadow scoreboard of EX/MEM/WB, load-use stall,
// redirect flush, operand forwarding selects and saturating event counters.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_have_inst,
    input  logic             id_rf_we,
    input  logic             id_is_load,
    input  logic [REG_W-1:0] id_rR1,
    input  logic [REG_W-1:0] id_rR2,
    input  logic [REG_W-1:0] id_wR,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic             ex_redirect,
    output logic             Lu_pipeline_stop,
    output logic             Cr_pipeline_stop,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] cr_flush_cnt
);

    sb_entry_t        r_ex;
    sb_entry_t        r_mem;
    sb_entry_t        r_wb;
    logic [CNT_W-1:0] r_luStallCnt;
    logic [CNT_W-1:0] r_crFlushCnt;

    sb_entry_t        w_idEntry;
    logic             w_exSrc;
    logic             w_memSrc;
    logic             w_wbSrc;
    logic [1:0]       w_selA;
    logic [1:0]       w_selB;
    logic             w_loadHitA;
    logic             w_loadHitB;
    logic             w_luStop;
    logic             w_crStop;
    logic             w_fwdEn;

    assign w_exSrc  = isSource(r_ex);
    assign w_memSrc = isSource(r_mem);
    assign w_wbSrc  = isSource(r_wb);

    hazard_fwd_sel u_fwdA (
        .i_re      (id_re1),
        .i_rR      (id_rR1),
        .i_exSrc   (w_exSrc),
        .i_exLoad  (r_ex.isLoad),
        .i_exWR    (r_ex.wR),
        .i_memSrc  (w_memSrc),
        .i_memWR   (r_mem.wR),
        .i_wbSrc   (w_wbSrc),
        .i_wbWR    (r_wb.wR),
        .o_sel     (w_selA),
        .o_loadHit (w_loadHitA)
    );

    hazard_fwd_sel u_fwdB (
        .i_re      (id_re2),
        .i_rR      (id_rR2),
        .i_exSrc   (w_exSrc),
        .i_exLoad  (r_ex.isLoad),
        .i_exWR    (r_ex.wR),
        .i_memSrc  (w_memSrc),
        .i_memWR   (r_mem.wR),
        .i_wbSrc   (w_wbSrc),
        .i_wbWR    (r_wb.wR),
        .o_sel     (w_selB),
        .o_loadHit (w_loadHitB)
    );

    // Gating with rst_n keeps every combinational output at 0 during reset,
    // even if the ID/EX inputs are still toggling.
    assign w_crStop = rst_n && ex_redirect;
    assign w_luStop = rst_n && id_have_inst && !ex_redirect && (w_loadHitA || w_loadHitB);
    assign w_fwdEn  = rst_n && id_have_inst && !w_luStop;

    assign Lu_pipeline_stop = w_luStop;
    assign Cr_pipeline_stop = w_crStop;
    assign pc_stall         = w_luStop;
    assign ifid_stall       = w_luStop;
    assign ifid_flush       = w_crStop;
    assign fwd_sel_a        = w_fwdEn ? w_selA : 2'b00;
    assign fwd_sel_b        = w_fwdEn ? w_selB : 2'b00;
    assign lu_stall_cnt     = r_luStallCnt;
    assign cr_flush_cnt     = r_crFlushCnt;

    always_comb begin
        w_idEntry = SB_BUBBLE;
        if (id_have_inst) begin
            w_idEntry.valid  = 1'b1;
            w_idEntry.rfWe   = id_rf_we;
            w_idEntry.isLoad = id_is_load;
            w_idEntry.wR     = id_wR;
        end
    end

    // The EX entry takes a bubble whenever ID/EX is cleared by a stall or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= SB_BUBBLE;
            r_mem <= SB_BUBBLE;
            r_wb  <= SB_BUBBLE;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= (w_luStop || w_crStop) ? SB_BUBBLE : w_idEntry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_luStallCnt <= '0;
            r_crFlushCnt <= '0;
        end else begin
            r_luStallCnt <= satInc(r_luStallCnt, w_luStop);
            r_crFlushCnt <= satInc(r_crFlushCnt, w_crStop);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic compared against an instruction-history reference model.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_have_inst, id_rf_we, id_is_load;
    logic [4:0]  id_rR1, id_rR2, id_wR;
    logic        id_re1, id_re2, ex_redirect;
    logic        Lu_pipeline_stop, Cr_pipeline_stop;
    logic        pc_stall, ifid_stall, ifid_flush;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic [15:0] lu_stall_cnt, cr_flush_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit valid;
        bit we;
        bit load;
        int rd;
    } instr_t;

    // hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB.
    instr_t      hist[$];
    instr_t      nopInstr;
    logic [15:0] modelLuCnt, modelCrCnt;
    logic        expLu, expCr;
    logic [1:0]  expA, expB;

    hazard_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_have_inst     (id_have_inst),
        .id_rf_we         (id_rf_we),
        .id_is_load       (id_is_load),
        .id_rR1           (id_rR1),
        .id_rR2           (id_rR2),
        .id_wR            (id_wR),
        .id_re1           (id_re1),
        .id_re2           (id_re2),
        .ex_redirect      (ex_redirect),
        .Lu_pipeline_stop (Lu_pipeline_stop),
        .Cr_pipeline_stop (Cr_pipeline_stop),
        .pc_stall         (pc_stall),
        .ifid_stall       (ifid_stall),
        .ifid_flush       (ifid_flush),
        .fwd_sel_a        (fwd_sel_a),
        .fwd_sel_b        (fwd_sel_b),
        .lu_stall_cnt     (lu_stall_cnt),
        .cr_flush_cnt     (cr_flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit writes(instr_t e);
        return e.valid && e.we && (e.rd != 0);
    endfunction

    function automatic logic [1:0] predictFwd(bit re, int r);
        if (!id_have_inst || !re || r == 0) return 2'd0;
        for (int age = 0; age < 3; age++) begin
            if (writes(hist[age]) && hist[age].rd == r)
                return (age == 0 && hist[age].load) ? 2'd0 : 2'(age + 1);
        end
        return 2'd0;
    endfunction

    task automatic modelReset();
        nopInstr = '{valid: 0, we: 0, load: 0, rd: 0};
        hist = {};
        repeat (3) hist.push_back(nopInstr);
        modelLuCnt = '0;
        modelCrCnt = '0;
    endtask

    task automatic modelEval();
        expCr = ex_redirect;
        expLu = id_have_inst && !ex_redirect && writes(hist[0]) && hist[0].load &&
                ((id_re1 && int'(id_rR1) == hist[0].rd) || (id_re2 && int'(id_rR2) == hist[0].rd));
        expA  = expLu ? 2'd0 : predictFwd(id_re1, int'(id_rR1));
        expB  = expLu ? 2'd0 : predictFwd(id_re2, int'(id_rR2));
    endtask

    task automatic tick();
        instr_t entered;
        modelEval();
        @(posedge clk);
        if (expLu || expCr || !id_have_inst)
            entered = nopInstr;
        else
            entered = '{valid: 1, we: id_rf_we, load: id_is_load, rd: int'(id_wR)};
        hist.push_front(entered);
        void'(hist.pop_back());
        if (expLu && modelLuCnt != 16'hFFFF) modelLuCnt = modelLuCnt + 1'b1;
        if (expCr && modelCrCnt != 16'hFFFF) modelCrCnt = modelCrCnt + 1'b1;
        #1;
    endtask

    task automatic applyStimulus(input bit have, input bit we, input bit ld,
                                 input int r1, input int r2, input int wr,
                                 input bit re1, input bit re2, input bit redir);
        id_have_inst = have;
        id_rf_we     = we;
        id_is_load   = ld;
        id_rR1       = 5'(r1);
        id_rR2       = 5'(r2);
        id_wR        = 5'(wr);
        id_re1       = re1;
        id_re2       = re2;
        ex_redirect  = redir;
    endtask

    task automatic drain();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1, 1, 1, 5, 5, 5, 1, 1, 1);
        modelReset();
        #3;
        checks++;
        if ({Lu_pipeline_stop, Cr_pipeline_stop, pc_stall, ifid_stall, ifid_flush} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {Lu_pipeline_stop, Cr_pipeline_stop, pc_stall, ifid_stall, ifid_flush});
        end
        checks++;
        if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_fwd: got a=%0d b=%0d expected 0/0", fwd_sel_a, fwd_sel_b);
        end
        checks++;
        if (lu_stall_cnt !== 16'h0 || cr_flush_cnt !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_cnt: got lu=%h cr=%h expected 0/0", lu_stall_cnt, cr_flush_cnt);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        applyStimulus(1, 1, 1, 2, 0, 5, 1, 0, 0);
        #1;
        checks++;
        if (Lu_pipeline_stop !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lu_issue: got Lu=%b expected 0", Lu_pipeline_stop);
        end
        tick();
        applyStimulus(1, 1, 0, 5, 1, 6, 1, 1, 0);
        #1;
        checks++;
        if ({Lu_pipeline_stop, pc_stall, ifid_stall} !== 3'b111 || fwd_sel_a !== 2'd0) begin
            errors++;
            $display("[TB] FAIL lu_stall: got Lu/pc/ifid=%b fwd_a=%0d expected 111/0",
                     {Lu_pipeline_stop, pc_stall, ifid_stall}, fwd_sel_a);
        end
        tick();
        #1;
        checks++;
        if ({Lu_pipeline_stop, pc_stall, ifid_stall} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL lu_once: got Lu/pc/ifid=%b expected 000",
                     {Lu_pipeline_stop, pc_stall, ifid_stall});
        end
        checks++;
        if (fwd_sel_a !== 2'd2 || fwd_sel_b !== 2'd0) begin
            errors++;
            $display("[TB] FAIL lu_fwd: got a=%0d b=%0d expected 2/0", fwd_sel_a, fwd_sel_b);
        end
        checks++;
        if (lu_stall_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL lu_cnt: got %0d expected 1", lu_stall_cnt);
        end
        tick();
        drain();
    endtask

    task automatic test_distance();
        for (int d = 1; d <= 3; d++) begin
            drain();
            applyStimulus(1, 1, 0, 0, 0, 5, 0, 0, 0);
            tick();
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            repeat (d - 1) tick();
            applyStimulus(1, 1, 0, 5, 5, 7, 1, 1, 0);
            #1;
            checks++;
            if (fwd_sel_a !== 2'(d) || fwd_sel_b !== 2'(d)) begin
                errors++;
                $display("[TB] FAIL dist%0d_fwd: got a=%0d b=%0d expected %0d", d, fwd_sel_a, fwd_sel_b, d);
            end
            checks++;
            if (Lu_pipeline_stop !== 1'b0 || pc_stall !== 1'b0) begin
                errors++;
                $display("[TB] FAIL dist%0d_stall: got Lu=%b pc=%b expected 0/0", d, Lu_pipeline_stop, pc_stall);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_x0();
        for (int ld = 0; ld < 2; ld++) begin
            applyStimulus(1, 1, bit'(ld), 0, 0, 0, 0, 0, 0);
            tick();
            applyStimulus(1, 1, 0, 0, 0, 3, 1, 1, 0);
            #1;
            checks++;
            if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0 || Lu_pipeline_stop !== 1'b0) begin
                errors++;
                $display("[TB] FAIL x0_read%0d: got a=%0d b=%0d Lu=%b expected 0/0/0",
                         ld, fwd_sel_a, fwd_sel_b, Lu_pipeline_stop);
            end
            tick();
            drain();
        end
    endtask

    task automatic test_redirect();
        logic [15:0] expCnt;
        applyStimulus(1, 1, 1, 2, 0, 5, 1, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 5, 1, 6, 1, 1, 1);
        #1;
        checks++;
        if ({Cr_pipeline_stop, ifid_flush} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL cr_flush: got Cr/flush=%b expected 11", {Cr_pipeline_stop, ifid_flush});
        end
        checks++;
        if ({Lu_pipeline_stop, pc_stall, ifid_stall} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL cr_prio: got Lu/pc/ifid=%b expected 000",
                     {Lu_pipeline_stop, pc_stall, ifid_stall});
        end
        expCnt = modelCrCnt + 16'd1;
        tick();
        applyStimulus(1, 1, 0, 5, 1, 6, 1, 1, 0);
        #1;
        checks++;
        if (cr_flush_cnt !== expCnt) begin
            errors++;
            $display("[TB] FAIL cr_cnt: got %0d expected %0d", cr_flush_cnt, expCnt);
        end
        checks++;
        if (Lu_pipeline_stop !== 1'b0 || fwd_sel_a !== 2'd2) begin
            errors++;
            $display("[TB] FAIL cr_bubble: got Lu=%b fwd_a=%0d expected 0/2", Lu_pipeline_stop, fwd_sel_a);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            #1;
            modelEval();
            checks++;
            if ({Lu_pipeline_stop, pc_stall, ifid_stall} !== {3{expLu}}) begin
                errors++;
                $display("[TB] FAIL rnd_lu[%0d]: got Lu/pc/ifid=%b expected %b",
                         i, {Lu_pipeline_stop, pc_stall, ifid_stall}, {3{expLu}});
            end
            checks++;
            if ({Cr_pipeline_stop, ifid_flush} !== {2{expCr}}) begin
                errors++;
                $display("[TB] FAIL rnd_cr[%0d]: got Cr/flush=%b expected %b",
                         i, {Cr_pipeline_stop, ifid_flush}, {2{expCr}});
            end
            checks++;
            if (fwd_sel_a !== expA || fwd_sel_b !== expB) begin
                errors++;
                $display("[TB] FAIL rnd_fwd[%0d]: got a=%0d b=%0d expected %0d/%0d",
                         i, fwd_sel_a, fwd_sel_b, expA, expB);
            end
            checks++;
            if (lu_stall_cnt !== modelLuCnt || cr_flush_cnt !== modelCrCnt) begin
                errors++;
                $display("[TB] FAIL rnd_cnt[%0d]: got lu=%0d cr=%0d expected %0d/%0d",
                         i, lu_stall_cnt, cr_flush_cnt, modelLuCnt, modelCrCnt);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_saturate();
        force dut.r_luStallCnt = 16'hFFFE;
        #1;
        release dut.r_luStallCnt;
        modelLuCnt = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 1, 1, 2, 0, 5, 1, 0, 0);
            tick();
            applyStimulus(1, 1, 0, 5, 1, 6, 1, 1, 0);
            tick();
            #1;
            checks++;
            if (lu_stall_cnt !== 16'hFFFF) begin
                errors++;
                $display("[TB] FAIL sat_cnt%0d: got %h expected FFFF", k, lu_stall_cnt);
            end
            tick();
        end
        drain();
        applyStimulus(1, 1, 1, 2, 0, 5, 1, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 5, 1, 6, 1, 1, 0);
        #1;
        checks++;
        if (Lu_pipeline_stop !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_stall: got Lu=%b expected 1", Lu_pipeline_stop);
        end
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checks++;
        if ({Lu_pipeline_stop, pc_stall, ifid_stall, fwd_sel_a, fwd_sel_b} !== 7'b0 ||
            lu_stall_cnt !== 16'h0 || cr_flush_cnt !== 16'h0) begin
            errors++;
            $display("[TB] FAIL async_rst: got Lu/pc/ifid/a/b=%b lu=%h cr=%h expected all 0",
                     {Lu_pipeline_stop, pc_stall, ifid_stall, fwd_sel_a, fwd_sel_b}, lu_stall_cnt, cr_flush_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (Lu_pipeline_stop !== 1'b0 || fwd_sel_a !== 2'd0) begin
            errors++;
            $display("[TB] FAIL post_rst: got Lu=%b fwd_a=%0d expected 0/0", Lu_pipeline_stop, fwd_sel_a);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_distance();
        test_x0();
        test_redirect();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports id_have_inst / id_rf_we / id_is_load, input, 1 each, ID-stage valid, reg-write and load (DRAM writeback) flags.
REQ-004 SHALL have ports id_rR1 / id_rR2 / id_wR, input, 5 each, ID source and destination registers.
REQ-005 SHALL have ports id_re1 / id_re2, input, 1 each, ID actually reads rs1 / rs2.
REQ-006 SHALL have port ex_redirect, input, 1, the EX-stage instruction is a taken branch or jump.
REQ-007 SHALL have outputs Lu_pipeline_stop and Cr_pipeline_stop, 1 each, the load-use bubble and control flush into the ID/EX register.
REQ-008 SHALL have outputs pc_stall / ifid_stall / ifid_flush, 1 each, PC hold, IF/ID hold and IF/ID kill.
REQ-009 SHALL have outputs fwd_sel_a / fwd_sel_b, 2 each, operand source: 0 regfile, 1 EX, 2 MEM, 3 WB.
REQ-010 SHALL have outputs lu_stall_cnt / cr_flush_cnt, 16 each, saturating event counters.

Function
REQ-011 SHALL keep a registered shadow scoreboard of EX, MEM and WB stages: valid, rf_we, is_load, wR per stage.
REQ-012 SHALL shift the scoreboard every cycle: WB<=MEM, MEM<=EX, EX<=ID fields gated by id_have_inst.
REQ-013 SHALL load an all-zero bubble into the EX entry when Lu_pipeline_stop or Cr_pipeline_stop is 1, mirroring ID/EX clearing.
REQ-014 SHALL treat a stage as a hazard source only if valid=1, rf_we=1 and wR!=0.
REQ-015 SHALL assert Lu_pipeline_stop combinationally when the EX entry is a load source and matches id_rR1 (id_re1=1) or id_rR2 (id_re2=1), with id_have_inst=1.
REQ-016 SHALL assert pc_stall and ifid_stall whenever Lu_pipeline_stop is 1; a single load-use costs exactly one bubble.
REQ-017 SHALL assert Cr_pipeline_stop and ifid_flush combinationally for every cycle ex_redirect is 1; pc_stall SHALL be 0 then.
REQ-018 SHALL give redirect priority: when ex_redirect=1, Lu_pipeline_stop, pc_stall and ifid_stall SHALL be 0.
REQ-019 SHALL select forwarding per operand with priority EX(1) > MEM(2) > WB(3) > regfile(0); a register index 0 or a read-disabled operand SHALL yield 0.
REQ-020 SHALL not select EX forwarding from a load; while stalled, fwd_sel values are don't-care and SHALL be 0.
REQ-021 SHALL increment lu_stall_cnt per cycle Lu_pipeline_stop=1 and cr_flush_cnt per cycle Cr_pipeline_stop=1, saturating at 16'hFFFF without wrap.

Reset
REQ-022 SHALL, while rst_n=0, clear all scoreboard entries and both counters asynchronously; all combinational outputs SHALL then read 0.
REQ-023 SHALL, on reset mid-stall or mid-flush, drop the event immediately; the first cycle after release sees an empty pipeline.

Structure
REQ-024 SHALL take the fwd_sel encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB) and the register-index width from the shared pipeline package.
REQ-025 SHALL implement the per-operand comparison in one sub-module, hazard_fwd_sel, instantiated twice (rs1, rs2).

Verification
REQ-026 SHALL cover lw x5 followed by add x6,x5,x1: exactly one cycle of Lu_pipeline_stop=pc_stall=ifid_stall=1, then fwd_sel_a=2, lu_stall_cnt=1.
REQ-027 SHALL cover add x5 with consumers at distance 1/2/3: fwd_sel_a=1, 2 and 3 respectively, and no stall.
REQ-028 SHALL cover a write to x0 followed by a read of x0: fwd_sel=0 and no stall.
REQ-029 SHALL cover ex_redirect=1 coinciding with a load-use match: Cr_pipeline_stop=ifid_flush=1, Lu_pipeline_stop=0, cr_flush_cnt +1, and the next EX entry a bubble.
REQ-030 SHALL cover forcing the counter to 16'hFFFF plus one more stall: it holds FFFF; rst_n=0 mid-stall clears all outputs asynchronously.
